fixed_to_float_norm: RTL and testbench



---
 rtl/fixed_to_float_norm_pkg.sv | 37 +++
 rtl/fixed_to_float_norm_fp_round_pack.sv | 72 +++++++
 rtl/fixed_to_float_norm.sv | 131 +++++++++++++
 tb/tb_fixed_to_float_norm.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_to_float_norm_pkg.sv
`default_nettype none
// ============================================================================
// Package     : fixed_float_pkg
// Description : Shared FSM state encoding, IEEE-754 single-precision field
//               constants and fixed-point format helpers for the
//               fixed_to_float_norm converter.
// Revision    : 1.0 - initial release
// ============================================================================
package fixed_float_pkg;

  // Converter FSM states (explicit 3-bit encoding)
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_ABS  = 3'd2,
    ST_NORM = 3'd3,
    ST_PACK = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  // IEEE-754 single-precision field layout
  localparam int FP_BIAS  = 127;
  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;

  // Default fixed-point format: Q5.26 in a 32-bit word
  localparam int DEF_W         = 32;
  localparam int DEF_FRAC_BITS = 26;
  localparam int FIX_INT_BITS  = DEF_W - 1 - DEF_FRAC_BITS;

  // Integer bits (excluding sign) of an arbitrary fixed-point format
  function automatic int fix_int_bits(input int w, input int frac_bits);
    return w - 1 - frac_bits;
  endfunction

endpackage : fixed_float_pkg
`default_nettype wire

// File: rtl/fixed_to_float_norm_fp_round_pack.sv
`default_nettype none
// ============================================================================
// Module      : fp_round_pack
// Description : Combinational packer. Turns a normalised magnitude, its sign
//               and the normalisation shift count into an IEEE-754 single.
//               A zero magnitude always yields +0.
//               Optional macro ROUND_NEAREST_EN: round-to-nearest-even on the
//               discarded magnitude bits; truncation when undefined.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_round_pack
  import fixed_float_pkg::*;
#(
  parameter int W         = 32,
  parameter int FRAC_BITS = 26,
  parameter int CNT_W     = 6
) (
  input  logic             sign,
  input  logic [W-1:0]     mag,
  input  logic [CNT_W-1:0] cnt,
  output logic [31:0]      result
);

  // Exponent of an un-shifted magnitude whose MSB sits at bit W-1
  localparam logic [8:0] EXP_BASE = 9'(FP_BIAS + fix_int_bits(W, FRAC_BITS));

  logic [8:0]          exp_norm;
  logic [8:0]          exp_final;
  logic [FP_MAN_W-1:0] man_trunc;
  logic [FP_MAN_W-1:0] man_final;

  // Each left shift during normalisation halves the represented weight
  assign exp_norm  = EXP_BASE - 9'(cnt);
  // Bit W-1 is the hidden one; the next 23 bits form the stored mantissa
  assign man_trunc = mag[W-2:W-1-FP_MAN_W];

`ifdef ROUND_NEAREST_EN
  logic          guard_bit;
  logic          sticky_bit;
  logic          lsb_bit;
  logic          round_up;
  logic [FP_MAN_W:0] man_sum;
  logic          unused_round;

  assign guard_bit  = mag[W-2-FP_MAN_W];
  assign sticky_bit = |mag[W-3-FP_MAN_W:0];
  assign lsb_bit    = mag[W-1-FP_MAN_W];
  assign round_up   = guard_bit & (sticky_bit | lsb_bit);
  // A carry out of the mantissa leaves it all-zero and bumps the exponent
  assign man_sum    = {1'b0, man_trunc} + {{FP_MAN_W{1'b0}}, round_up};
  assign man_final  = man_sum[FP_MAN_W-1:0];
  assign exp_final  = exp_norm + {8'd0, man_sum[FP_MAN_W]};
  assign unused_round = mag[W-1] ^ exp_final[8];
`else
  logic unused_trunc;

  assign man_final    = man_trunc;
  assign exp_final    = exp_norm;
  // Discarded low bits and the implicit one are intentionally not used
  assign unused_trunc = (^mag[W-2-FP_MAN_W:0]) ^ mag[W-1] ^ exp_final[8];
`endif

  // Assemble the float; zero magnitude forces +0 regardless of sign
  always_comb begin
    result = 32'h0000_0000;
    if (mag != '0) begin
      result = {sign, exp_final[FP_EXP_W-1:0], man_final};
    end
  end

endmodule : fp_round_pack
`default_nettype wire

// File: rtl/fixed_to_float_norm.sv
`default_nettype none
// ============================================================================
// Module      : fixed_to_float_norm
// Description : Multi-cycle signed fixed-point to IEEE-754 single converter.
//               Begin/ack handshake with a synchronous FSM reset. The
//               magnitude is normalised serially, one left shift per cycle,
//               and packed by fp_round_pack.
//               Optional macro ROUND_NEAREST_EN (see fp_round_pack).
// Revision    : 1.0 - initial release
// ============================================================================
module fixed_to_float_norm
  import fixed_float_pkg::*;
#(
  parameter int W         = 32,
  parameter int FRAC_BITS = 26
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         RST_FSM,
  input  logic         BEGIN_FSM,
  input  logic [W-1:0] FIXED,
  output logic         ACK,
  output logic         BUSY,
  output logic [31:0]  FLOAT
);

  localparam int CNT_W   = $clog2(W) + 1;
  // Reachable exponent range, including a possible rounding carry
  localparam int EXP_MAX = FP_BIAS + fix_int_bits(W, FRAC_BITS) + 1;
  localparam int EXP_MIN = FP_BIAS + fix_int_bits(W, FRAC_BITS) - (W - 1);

  // Parameter sets that would need denormal/overflow handling are rejected
  if ((EXP_MIN < 1) || (EXP_MAX > 254) || (W < FP_MAN_W + 3)) begin : g_param_check
    $error("fixed_to_float_norm: W/FRAC_BITS give an exponent outside the normal range");
  end

  state_t             state;
  state_t             state_next;
  logic [W-1:0]       op;
  logic               sign;
  logic [W-1:0]       mag;
  logic [W-1:0]       abs_val;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        packed_float;

  // Magnitude of the captured operand; the most negative value maps to 2^(W-1)
  assign abs_val = sign ? (~op + {{(W-1){1'b0}}, 1'b1}) : op;

  // FSM state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; the FSM reset overrides every transition
  always_comb begin
    state_next = state;
    if (RST_FSM) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (BEGIN_FSM) state_next = ST_LOAD;
        ST_LOAD: state_next = ST_ABS;
        ST_ABS: begin
          if ((abs_val == '0) || abs_val[W-1]) state_next = ST_PACK;
          else                                 state_next = ST_NORM;
        end
        // Leave once the value being shifted in will have its MSB set
        ST_NORM: if (mag[W-2]) state_next = ST_PACK;
        ST_PACK: state_next = ST_DONE;
        ST_DONE: state_next = ST_DONE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Datapath registers; they hold while the FSM reset is asserted
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      op    <= '0;
      sign  <= 1'b0;
      mag   <= '0;
      cnt   <= '0;
      FLOAT <= 32'h0000_0000;
    end else if (!RST_FSM) begin
      case (state)
        ST_LOAD: begin
          op   <= FIXED;
          sign <= FIXED[W-1];
        end
        ST_ABS: begin
          mag <= abs_val;
          cnt <= '0;
        end
        ST_NORM: begin
          mag <= {mag[W-2:0], 1'b0};
          cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        ST_PACK: FLOAT <= packed_float;
        default: ;
      endcase
    end
  end

  // ACK rises the cycle after DONE is entered and drops with the FSM reset
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ACK <= 1'b0;
    end else begin
      ACK <= (state == ST_DONE) && !RST_FSM;
    end
  end

  assign BUSY = (state != ST_IDLE) && (state != ST_DONE);

  fp_round_pack #(
    .W         (W),
    .FRAC_BITS (FRAC_BITS),
    .CNT_W     (CNT_W)
  ) u_round_pack (
    .sign   (sign),
    .mag    (mag),
    .cnt    (cnt),
    .result (packed_float)
  );

endmodule : fixed_to_float_norm
`default_nettype wire

// File: tb/tb_fixed_to_float_norm.sv
`default_nettype none
// ============================================================================
// Module      : tb_fixed_to_float_norm
// Description : Directed self-checking bench for fixed_to_float_norm (W=32,
//               FRAC_BITS=26). Expected floats are hand-computed constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fixed_to_float_norm;

  logic        CLK;
  logic        RST_N;
  logic        RST_FSM;
  logic        BEGIN_FSM;
  logic [31:0] FIXED;
  logic        ACK;
  logic        BUSY;
  logic [31:0] FLOAT;

  int checks;
  int failures;

  fixed_to_float_norm #(
    .W         (32),
    .FRAC_BITS (26)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .RST_FSM   (RST_FSM),
    .BEGIN_FSM (BEGIN_FSM),
    .FIXED     (FIXED),
    .ACK       (ACK),
    .BUSY      (BUSY),
    .FLOAT     (FLOAT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Run one conversion: edge 0 samples BEGIN_FSM; returns the edge count
  // after which ACK was seen, the result, BUSY after edge 0 and whether the
  // FSM reset pulse cleared ACK/BUSY. FIXED is scrambled after LOAD.
  task automatic convert(input logic [31:0] fx, output logic [31:0] flt,
                         output int edges, output logic busy0,
                         output logic cleared);
    edges = -1;
    @(negedge CLK);
    FIXED     = fx;
    BEGIN_FSM = 1'b1;
    @(posedge CLK);
    #1;
    BEGIN_FSM = 1'b0;
    busy0 = BUSY;
    for (int n = 1; n <= 60; n++) begin
      @(posedge CLK);
      #1;
      if (n == 1) FIXED = ~fx;
      if (ACK) begin
        edges = n;
        break;
      end
    end
    flt = FLOAT;
    @(negedge CLK);
    RST_FSM = 1'b1;
    @(posedge CLK);
    #1;
    RST_FSM = 1'b0;
    cleared = !ACK && !BUSY;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; RST_FSM = 1'b0; BEGIN_FSM = 1'b0; FIXED = 32'h0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (ACK !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", ACK); end
    checks++;
    if (BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
    checks++;
    if (FLOAT !== 32'h0) begin failures++; $display("FAIL reset_float got=%h exp=00000000", FLOAT); end
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  // Vector conversion with its own inline checks
  task automatic test_vector(input string name, input logic [31:0] fx,
                             input logic [31:0] exp_flt, input int exp_edges);
    logic [31:0] flt;
    int          edges;
    logic        busy0;
    logic        cleared;
    convert(fx, flt, edges, busy0, cleared);
    checks++;
    if (flt !== exp_flt) begin
      failures++; $display("FAIL %s_float got=%h exp=%h", name, flt, exp_flt);
    end
    checks++;
    if (edges != exp_edges) begin
      failures++; $display("FAIL %s_latency got=%0d exp=%0d", name, edges, exp_edges);
    end
    checks++;
    if (busy0 !== 1'b1) begin
      failures++; $display("FAIL %s_busy got=%b exp=1", name, busy0);
    end
    checks++;
    if (cleared !== 1'b1) begin
      failures++; $display("FAIL %s_ack_clear got=%b exp=1", name, cleared);
    end
  endtask

  task automatic test_conversions();
    test_vector("one",     32'h0400_0000, 32'h3F80_0000, 9);
    test_vector("neg2p5",  32'hF600_0000, 32'hC020_0000, 8);
    test_vector("minneg",  32'h8000_0000, 32'hC200_0000, 4);
    test_vector("zero",    32'h0000_0000, 32'h0000_0000, 4);
    test_vector("pos2p5",  32'h0A00_0000, 32'h4020_0000, 8);
    test_vector("negone",  32'hFC00_0000, 32'hBF80_0000, 9);
  endtask

  task automatic test_rounding();
`ifdef ROUND_NEAREST_EN
    test_vector("round_up",   32'h07FF_FFFF, 32'h4000_0000, 9);
    test_vector("round_even", 32'h0400_0004, 32'h3F80_0000, 9);
`else
    test_vector("trunc",      32'h07FF_FFFF, 32'h3FFF_FFFF, 9);
    test_vector("trunc_low",  32'h0400_0004, 32'h3F80_0000, 9);
`endif
  endtask

  // DONE ignores BEGIN_FSM; BEGIN held across DONE->IDLE starts at once
  task automatic test_back_to_back();
    int   edges;
    logic seen;
    @(negedge CLK);
    FIXED = 32'h0A00_0000; BEGIN_FSM = 1'b1;
    @(posedge CLK); #1;
    seen = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge CLK); #1;
      if (ACK) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL b2b_first_ack got=0 exp=1"); end
    FIXED = 32'h8000_0000;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (ACK !== 1'b1 || FLOAT !== 32'h4020_0000) begin
      failures++; $display("FAIL b2b_done_hold ack=%b float=%h exp ack=1 float=40200000", ACK, FLOAT);
    end
    @(negedge CLK);
    RST_FSM = 1'b1;
    @(posedge CLK); #1;
    RST_FSM = 1'b0;
    checks++;
    if (ACK !== 1'b0) begin failures++; $display("FAIL b2b_ack_drop got=%b exp=0", ACK); end
    @(posedge CLK); #1;
    BEGIN_FSM = 1'b0;
    edges = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge CLK); #1;
      if (ACK) begin edges = n; break; end
    end
    checks++;
    if (edges != 4) begin failures++; $display("FAIL b2b_latency got=%0d exp=4", edges); end
    checks++;
    if (FLOAT !== 32'hC200_0000) begin
      failures++; $display("FAIL b2b_float got=%h exp=c2000000", FLOAT);
    end
    @(negedge CLK); RST_FSM = 1'b1;
    @(posedge CLK); #1; RST_FSM = 1'b0;
  endtask

  // FSM reset during NORM aborts the conversion; FLOAT holds
  task automatic test_rst_fsm_abort();
    logic ack_seen;
    @(negedge CLK);
    FIXED = 32'h0000_0001; BEGIN_FSM = 1'b1;
    @(posedge CLK); #1;
    BEGIN_FSM = 1'b0;
    repeat (6) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (BUSY !== 1'b1) begin failures++; $display("FAIL rstfsm_busy_norm got=%b exp=1", BUSY); end
    RST_FSM = 1'b1;
    @(posedge CLK); #1;
    RST_FSM = 1'b0;
    checks++;
    if (BUSY !== 1'b0 || ACK !== 1'b0) begin
      failures++; $display("FAIL rstfsm_idle busy=%b ack=%b exp 0 0", BUSY, ACK);
    end
    ack_seen = 1'b0;
    for (int n = 0; n < 45; n++) begin
      @(posedge CLK); #1;
      if (ACK || BUSY) ack_seen = 1'b1;
    end
    checks++;
    if (ack_seen) begin failures++; $display("FAIL rstfsm_no_ack got=1 exp=0"); end
    checks++;
    if (FLOAT !== 32'hC200_0000) begin
      failures++; $display("FAIL rstfsm_float_hold got=%h exp=c2000000", FLOAT);
    end
  endtask

  // Asynchronous reset mid-conversion clears outputs without a clock edge
  task automatic test_rst_n_abort();
    @(negedge CLK);
    FIXED = 32'h0000_0001; BEGIN_FSM = 1'b1;
    @(posedge CLK); #1;
    BEGIN_FSM = 1'b0;
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    checks++;
    if (ACK !== 1'b0 || BUSY !== 1'b0 || FLOAT !== 32'h0) begin
      failures++; $display("FAIL rstn_async ack=%b busy=%b float=%h exp 0 0 00000000", ACK, BUSY, FLOAT);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_tiny();
    test_vector("tiny", 32'h0000_0001, 32'h3280_0000, 35);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_conversions();
    test_rounding();
    test_back_to_back();
    test_rst_fsm_abort();
    test_rst_n_abort();
    test_tiny();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fixed_to_float_norm
`default_nettype wire
